axis_packet_arbiter: RTL and testbench

AXIS_PACKET_ARBITER -- requirements
Module: axis_packet_arbiter

---
 rtl/axis_packet_arbiter.sv | 172 +++++++++++++++++
 tb/tb_axis_packet_arbiter.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_packet_arbiter.sv
// -----------------------------------------------------------------------------
// axis_packet_arbiter
//   Round-robin, packet-granular arbiter merging NUM_PORTS AXI-Stream slave
//   ports onto one master port through a one-beat output register.
//   A port holds the grant from its first beat up to its tlast beat. After that
//   the arbiter spends one idle cycle in ARB before it grants the next packet.
//
// Ports
//   i_clk, i_aresetn          clock, asynchronous active-low reset
//   i_tvalid/o_tready         per-port handshake (NUM_PORTS bits)
//   i_tdata/i_tkeep/i_tlast   per-port payload, port p at slice p*W +: W
//   o_tvalid/i_tready         master handshake
//   o_tdata/o_tkeep/o_tlast   registered master payload
//   o_tdest                   constant TDEST
//   o_tid                     index of the port that sourced the beat
//   o_grant                   one-hot granted port, zero while arbitrating
//   o_busy                    packet granted or output register occupied
// -----------------------------------------------------------------------------
module axis_packet_arbiter #(
  parameter int BUS_WIDTH = 16,
  parameter int NUM_PORTS = 4,
  parameter int TDEST     = 2
) (
  input  logic                               i_clk,
  input  logic                               i_aresetn,
  input  logic [NUM_PORTS-1:0]               i_tvalid,
  output logic [NUM_PORTS-1:0]               o_tready,
  input  logic [NUM_PORTS*BUS_WIDTH-1:0]     i_tdata,
  input  logic [NUM_PORTS*(BUS_WIDTH/8)-1:0] i_tkeep,
  input  logic [NUM_PORTS-1:0]               i_tlast,
  output logic                               o_tvalid,
  input  logic                               i_tready,
  output logic [BUS_WIDTH-1:0]               o_tdata,
  output logic [BUS_WIDTH/8-1:0]             o_tkeep,
  output logic                               o_tlast,
  output logic [7:0]                         o_tdest,
  output logic [7:0]                         o_tid,
  output logic [NUM_PORTS-1:0]               o_grant,
  output logic                               o_busy
);

  localparam int KW = BUS_WIDTH / 8;
  localparam int IW = $clog2(NUM_PORTS);
  localparam int SW = IW + 1;

  typedef enum logic {ARB, GRANT} state_e;

  state_e                 state_q;
  logic [IW-1:0]          rr_q;
  logic [IW-1:0]          gidx_q;
  logic [NUM_PORTS-1:0]   grant_q;
  logic                   tvalid_q;
  logic [BUS_WIDTH-1:0]   tdata_q;
  logic [KW-1:0]          tkeep_q;
  logic                   tlast_q;
  logic [7:0]             tid_q;

  // Arbitration results, applied only while in ARB
  logic [NUM_PORTS-1:0]   rot_valid;
  logic                   found;
  logic [SW-1:0]          off;
  logic [SW-1:0]          sum;
  logic [SW-1:0]          nxt;
  logic [IW-1:0]          gidx_d;
  logic [IW-1:0]          rr_d;
  logic [NUM_PORTS-1:0]   grant_d;

  // Granted-port payload
  logic [BUS_WIDTH-1:0]   sel_data;
  logic [KW-1:0]          sel_keep;
  logic                   sel_last;
  logic                   in_hs;

  // Rotate the valids so that bit 0 corresponds to rr_q. The lowest set bit
  // then gives the offset of the winner. The index wraps modulo NUM_PORTS
  // explicitly, so NUM_PORTS does not have to be a power of two.
  always_comb begin
    rot_valid = (i_tvalid >> rr_q) | (i_tvalid << (NUM_PORTS - int'(rr_q)));
    found     = 1'b0;
    off       = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      if (!found && rot_valid[k]) begin
        found = 1'b1;
        off   = SW'(k);
      end
    end
    sum = {1'b0, rr_q} + off;
    if (sum >= SW'(NUM_PORTS)) sum = sum - SW'(NUM_PORTS);
    nxt = sum + SW'(1);
    if (nxt == SW'(NUM_PORTS)) nxt = '0;
    gidx_d  = sum[IW-1:0];
    rr_d    = nxt[IW-1:0];
    grant_d = NUM_PORTS'(1) << gidx_d;
  end

  always_comb begin
    sel_data = '0;
    sel_keep = '0;
    sel_last = 1'b0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (gidx_q == IW'(p)) begin
        sel_data = i_tdata[p*BUS_WIDTH +: BUS_WIDTH];
        sel_keep = i_tkeep[p*KW +: KW];
        sel_last = i_tlast[p];
      end
    end
  end

  // Accept a beat only when the output register is empty or is drained in this cycle
  always_comb begin
    o_tready = '0;
    if (state_q == GRANT && (!tvalid_q || i_tready)) o_tready = grant_q;
  end

  assign in_hs = |(o_tready & i_tvalid);

  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      state_q  <= ARB;
      rr_q     <= '0;
      gidx_q   <= '0;
      grant_q  <= '0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tkeep_q  <= '0;
      tlast_q  <= 1'b0;
      tid_q    <= '0;
    end else begin
      case (state_q)
        ARB: begin
          if (found) begin
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            rr_q    <= rr_d;
            state_q <= GRANT;
          end else begin
            grant_q <= '0;
          end
        end
        GRANT: begin
          if (in_hs && sel_last) begin
            grant_q <= '0;
            state_q <= ARB;
          end
        end
        default: state_q <= ARB;
      endcase

      // Load and drain in the same cycle keep tvalid high, so a packet
      // streams at one beat per cycle.
      if (in_hs) begin
        tvalid_q <= 1'b1;
        tdata_q  <= sel_data;
        tkeep_q  <= sel_keep;
        tlast_q  <= sel_last;
        tid_q    <= 8'(gidx_q);
      end else if (tvalid_q && i_tready) begin
        tvalid_q <= 1'b0;
      end
    end
  end

  assign o_tvalid = tvalid_q;
  assign o_tdata  = tdata_q;
  assign o_tkeep  = tkeep_q;
  assign o_tlast  = tlast_q;
  assign o_tid    = tid_q;
  assign o_tdest  = 8'(TDEST);
  assign o_grant  = grant_q;
  assign o_busy   = (state_q == GRANT) || tvalid_q;

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axis_packet_arbiter
//   Scoreboard bench for axis_packet_arbiter. A 4-port instance runs directed
//   scenarios, and a 3-port instance runs random valid/ready traffic. Drivers
//   take beats from per-port source queues. Expected beats and grants are
//   queued when the stimulus is issued. Monitors pop the expected values on
//   every output handshake and on every rising edge of the grant.
// -----------------------------------------------------------------------------
module tb_axis_packet_arbiter;

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  keep;
    logic        last;
    logic [7:0]  tid;
  } beat_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // ---------------- 4-port instance ----------------
  logic [3:0]  vld4   = '0;
  logic [3:0]  rdy4;
  logic [63:0] data4  = '0;
  logic [7:0]  keep4  = '0;
  logic [3:0]  last4  = '0;
  logic        ovld4;
  logic        ordy4  = 1'b1;
  logic [15:0] odata4;
  logic [1:0]  okeep4;
  logic        olast4;
  logic [7:0]  odest4;
  logic [7:0]  otid4;
  logic [3:0]  grant4;
  logic        busy4;

  axis_packet_arbiter #(.BUS_WIDTH(16), .NUM_PORTS(4), .TDEST(2)) u4 (
    .i_clk(clk), .i_aresetn(rst_n),
    .i_tvalid(vld4), .o_tready(rdy4), .i_tdata(data4), .i_tkeep(keep4), .i_tlast(last4),
    .o_tvalid(ovld4), .i_tready(ordy4), .o_tdata(odata4), .o_tkeep(okeep4), .o_tlast(olast4),
    .o_tdest(odest4), .o_tid(otid4), .o_grant(grant4), .o_busy(busy4)
  );

  // ---------------- 3-port instance ----------------
  logic [2:0]  vld3   = '0;
  logic [2:0]  rdy3;
  logic [47:0] data3  = '0;
  logic [5:0]  keep3  = '0;
  logic [2:0]  last3  = '0;
  logic        ovld3;
  logic        ordy3  = 1'b0;
  logic [15:0] odata3;
  logic [1:0]  okeep3;
  logic        olast3;
  logic [7:0]  odest3;
  logic [7:0]  otid3;
  logic [2:0]  grant3;
  logic        busy3;

  axis_packet_arbiter #(.BUS_WIDTH(16), .NUM_PORTS(3), .TDEST(2)) u3 (
    .i_clk(clk), .i_aresetn(rst_n),
    .i_tvalid(vld3), .o_tready(rdy3), .i_tdata(data3), .i_tkeep(keep3), .i_tlast(last3),
    .o_tvalid(ovld3), .i_tready(ordy3), .o_tdata(odata3), .o_tkeep(okeep3), .o_tlast(olast3),
    .o_tdest(odest3), .o_tid(otid3), .o_grant(grant3), .o_busy(busy3)
  );

  beat_t      src4[4][$];
  beat_t      exp4[$];
  logic [3:0] expg[$];
  beat_t      src3[3][$];
  beat_t      exp3[3][$];

  bit         gap_chk = 1'b0;
  int         gap     = 0;
  logic [3:0] prev_g  = '0;
  int         tlast3  = 0;
  int         pkts3   = 0;
  bit         in_pkt3 = 1'b0;
  int         cur3    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  task automatic push4(input int p, input logic [15:0] d, input logic [1:0] k, input logic l);
    beat_t b;
    b.data = d; b.keep = k; b.last = l; b.tid = 8'(p);
    src4[p].push_back(b);
    exp4.push_back(b);
  endtask

  function automatic int pending4();
    return exp4.size() + expg.size() + src4[0].size() + src4[1].size() +
           src4[2].size() + src4[3].size();
  endfunction

  task automatic wait_idle(input string name);
    int n = 0;
    while (pending4() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (pending4() != 0) fail(name);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_ovld(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ovld4 && n < 50);
    if (!ovld4) fail(name);
  endtask

  task automatic wait_grant(input logic [3:0] g, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (grant4 !== g && n < 50);
    if (grant4 !== g) fail(name);
  endtask

  // Source drivers: sample the handshakes mid-cycle, then advance the queues just after the edge
  always begin : drv4
    logic [3:0] hs;
    beat_t      b;
    @(negedge clk);
    hs = rdy4 & vld4;
    @(posedge clk);
    #1;
    for (int p = 0; p < 4; p++) begin
      if (hs[p] && src4[p].size() > 0) void'(src4[p].pop_front());
      if (src4[p].size() > 0) begin
        b = src4[p][0];
        vld4[p] = 1'b1; data4[p*16 +: 16] = b.data; keep4[p*2 +: 2] = b.keep; last4[p] = b.last;
      end else begin
        vld4[p] = 1'b0; data4[p*16 +: 16] = '0; keep4[p*2 +: 2] = '0; last4[p] = 1'b0;
      end
    end
  end

  // Random source for the 3-port instance: once valid is raised it is held until the handshake
  always begin : drv3
    logic [2:0] hs;
    beat_t      b;
    @(negedge clk);
    hs = rdy3 & vld3;
    @(posedge clk);
    #1;
    for (int p = 0; p < 3; p++) begin
      if (hs[p] && src3[p].size() > 0) begin
        void'(src3[p].pop_front());
        vld3[p] = 1'b0;
      end
      if (!vld3[p] && src3[p].size() > 0 && $urandom_range(0, 2) != 0) vld3[p] = 1'b1;
      if (vld3[p]) begin
        b = src3[p][0];
        data3[p*16 +: 16] = b.data; keep3[p*2 +: 2] = b.keep; last3[p] = b.last;
      end else begin
        data3[p*16 +: 16] = '0; keep3[p*2 +: 2] = '0; last3[p] = 1'b0;
      end
    end
    ordy3 = ($urandom_range(0, 3) != 0);
  end

  always @(negedge clk) begin : mon4
    beat_t e;
    if (rst_n && ovld4 && ordy4) begin
      if (exp4.size() == 0) begin
        fail("u4_unexpected_beat");
      end else begin
        e = exp4.pop_front();
        chk("u4_tdata", odata4, e.data);
        chk("u4_tkeep", okeep4, e.keep);
        chk("u4_tlast", olast4, e.last);
        chk("u4_tid", otid4, e.tid);
        chk("u4_tdest", odest4, 2);
      end
    end
    if (grant4 != 0 && prev_g == 0) begin
      if (expg.size() == 0) fail("u4_unexpected_grant");
      else chk("u4_grant", grant4, expg.pop_front());
      if (gap_chk) chk("u4_bubble", gap, 1);
      gap = 0;
    end else if (grant4 == 0) begin
      gap++;
    end
    prev_g = grant4;
  end

  always @(negedge clk) begin : mon3
    beat_t e;
    int    t;
    if (rst_n && ovld3 && ordy3) begin
      t = int'(otid3);
      if (t > 2) begin
        fail("u3_bad_tid");
      end else if (exp3[t].size() == 0) begin
        fail("u3_unexpected_beat");
      end else begin
        e = exp3[t].pop_front();
        chk("u3_tdata", odata3, e.data);
        chk("u3_tkeep", okeep3, e.keep);
        chk("u3_tlast", olast3, e.last);
        if (in_pkt3) chk("u3_no_interleave", t, cur3);
        in_pkt3 = !olast3;
        cur3    = t;
        if (olast3) tlast3++;
      end
    end
  end

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tvalid", ovld4, 0);
    chk("rst_tdata", odata4, 0);
    chk("rst_tkeep", okeep4, 0);
    chk("rst_tlast", olast4, 0);
    chk("rst_tid", otid4, 0);
    chk("rst_grant", grant4, 0);
    chk("rst_tready", rdy4, 0);
    chk("rst_busy", busy4, 0);
    chk("rst_tdest", odest4, 2);
    @(negedge clk);
    rst_n = 1'b1;

    // Port 2 alone sends three beats A, B, C
    expg.push_back(4'b0100);
    push4(2, 16'hA001, 2'b11, 1'b0);
    push4(2, 16'hB002, 2'b11, 1'b0);
    push4(2, 16'hC003, 2'b01, 1'b1);
    wait_ovld("t1_no_output");
    chk("t1_busy", busy4, 1);
    repeat (2) begin
      @(negedge clk);
      chk("t1_consecutive", ovld4, 1);
    end
    wait_idle("t1_timeout");

    // Reset again so that the round-robin pointer is back at port 0
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // All four ports valid with 1-beat packets: grant order 0,1,2,3,0
    expg.push_back(4'b0001); expg.push_back(4'b0010); expg.push_back(4'b0100);
    expg.push_back(4'b1000); expg.push_back(4'b0001);
    push4(0, 16'h0A00, 2'b11, 1'b1);
    push4(1, 16'h1A00, 2'b11, 1'b1);
    push4(2, 16'h2A00, 2'b11, 1'b1);
    push4(3, 16'h3A00, 2'b11, 1'b1);
    push4(0, 16'h0B00, 2'b10, 1'b1);
    wait_grant(4'b0001, "t2_first_grant");
    @(posedge clk);
    #1 gap_chk = 1'b1;
    wait_idle("t2_timeout");
    gap_chk = 1'b0;

    // The master stalls for 5 cycles in the middle of a port 1 packet
    expg.push_back(4'b0010);
    push4(1, 16'h3000, 2'b11, 1'b0);
    push4(1, 16'h3001, 2'b11, 1'b0);
    push4(1, 16'h3002, 2'b11, 1'b0);
    push4(1, 16'h3003, 2'b11, 1'b1);
    wait_ovld("t3_no_output");
    @(posedge clk);
    #1 ordy4 = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("t3_hold_tdata", odata4, 16'h3001);
      chk("t3_hold_tvalid", ovld4, 1);
      chk("t3_tready_low", rdy4[1], 0);
    end
    @(posedge clk);
    #1 ordy4 = 1'b1;
    wait_idle("t3_timeout");

    // Port 0 raises valid while a port 1 packet is in progress
    expg.push_back(4'b0010); expg.push_back(4'b0001);
    push4(1, 16'h4000, 2'b11, 1'b0);
    push4(1, 16'h4001, 2'b11, 1'b0);
    push4(1, 16'h4002, 2'b11, 1'b0);
    push4(1, 16'h4003, 2'b11, 1'b1);
    wait_grant(4'b0010, "t4_port1_grant");
    push4(0, 16'h4A00, 2'b01, 1'b1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("t4_grant_held", grant4, 4'b0010);
    wait_idle("t4_timeout");

    // Reset asserted in the middle of a port 3 packet while a beat is buffered
    expg.push_back(4'b1000);
    push4(3, 16'h5000, 2'b11, 1'b0);
    push4(3, 16'h5001, 2'b11, 1'b0);
    push4(3, 16'h5002, 2'b11, 1'b0);
    push4(3, 16'h5003, 2'b11, 1'b1);
    wait_ovld("t5_no_output");
    @(posedge clk);
    #1 ordy4 = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_tvalid", ovld4, 0);
    chk("t5_async_tdata", odata4, 0);
    chk("t5_async_tkeep", okeep4, 0);
    chk("t5_async_tlast", olast4, 0);
    chk("t5_async_tid", otid4, 0);
    chk("t5_async_grant", grant4, 0);
    chk("t5_async_tready", rdy4, 0);
    chk("t5_async_busy", busy4, 0);
    chk("t5_tdest", odest4, 2);
    exp4.delete();
    src4[3].delete();
    expg.delete();
    expg.push_back(4'b0001); expg.push_back(4'b1000);
    push4(0, 16'h6000, 2'b11, 1'b1);
    push4(3, 16'h6300, 2'b11, 1'b1);
    ordy4 = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk("t5_first_grant_port0", grant4, 4'b0001);
    wait_idle("t5_timeout");

    // Random traffic on the 3-port instance
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 4; k++) begin
        int    len;
        beat_t b;
        len = $urandom_range(1, 4);
        for (int i = 0; i < len; i++) begin
          b.data = {4'(p), 4'(k), 8'(i)};
          b.last = (i == len - 1);
          b.keep = b.last ? 2'b01 : 2'b11;
          b.tid  = 8'(p);
          src3[p].push_back(b);
          exp3[p].push_back(b);
        end
        pkts3++;
      end
    end
    begin
      int n = 0;
      while ((exp3[0].size() + exp3[1].size() + exp3[2].size()) != 0 && n < 3000) begin
        @(negedge clk);
        n++;
      end
      if ((exp3[0].size() + exp3[1].size() + exp3[2].size()) != 0) fail("u3_timeout");
    end
    chk("u3_tlast_count", tlast3, pkts3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

endmodule
